// File: rtl/rv32_pkg.sv
// rv32_pkg: shared integer register file constants
package rv32_pkg;
    localparam int XLEN = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/wb_load_queue.sv
// wb_load_queue: FIFO of pending load returns {rd, data} with wrap-bit pointers
module wb_load_queue
    import rv32_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W = REG_ADDR_W + XLEN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wp;
    logic [AW:0]  r_rp;
    assign o_empty = r_wp == r_rp;
    assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign o_data  = r_mem[r_rp[AW-1:0]];
    // pointers advance on push/pop; the caller never pushes when full or pops when empty
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (i_push) r_wp <= r_wp + 1'b1;
            if (i_pop) r_rp <= r_rp + 1'b1;
        end
    end
    // storage needs no reset: the empty flag guards stale contents
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wp[AW-1:0]] <= i_data;
    end
endmodule

// File: rtl/rf_writeback.sv
// rf_writeback: arbitrates ALU results and load returns onto the register file write port
module rf_writeback #(
    parameter int XLEN = rv32_pkg::XLEN,
    parameter int LQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_issue,
    input  logic [4:0]      ld_issue_rd,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [4:0]      chk_rd,
    output logic            stall,
    output logic [4:0]      WA,
    output logic            WE,
    output logic [XLEN-1:0] WD
);
    import rv32_pkg::*;
    localparam int EW = REG_ADDR_W + XLEN;
    logic                  w_alu_win;
    logic                  w_acc;
    logic                  w_q_win;
    logic                  w_byp;
    logic                  w_win;
    logic                  w_full;
    logic                  w_empty;
    logic [EW-1:0]         w_head;
    logic [REG_ADDR_W-1:0] w_wa;
    logic [XLEN-1:0]       w_wd;
    logic [NUM_REGS-1:0]   w_set;
    logic [NUM_REGS-1:0]   w_clr;
    logic [NUM_REGS-1:0]   r_pend;
    logic [REG_ADDR_W-1:0] r_wa;
    logic [XLEN-1:0]       r_wd;
    logic                  r_we;
    logic                  r_ld;
    assign ld_ready  = !rst && !w_full;
    assign w_alu_win = alu_valid && alu_rd != REG_ZERO;
    assign w_acc     = ld_valid && ld_ready && ld_rd != REG_ZERO;
    assign w_q_win   = !w_alu_win && !w_empty;
    assign w_byp     = !w_alu_win && w_empty && w_acc;
    assign w_win     = w_alu_win || w_q_win || w_byp;
    assign w_wa      = w_alu_win ? alu_rd : w_q_win ? w_head[EW-1:XLEN] : ld_rd;
    assign w_wd      = w_alu_win ? alu_data : w_q_win ? w_head[XLEN-1:0] : ld_data;
    wb_load_queue #(.DEPTH(LQ_DEPTH), .W(EW)) u_lq (
        .clk    (clk),
        .rst    (rst),
        .i_push (w_acc && !w_byp),
        .i_pop  (w_q_win),
        .i_data ({ld_rd, ld_data}),
        .o_data (w_head),
        .o_full (w_full),
        .o_empty(w_empty)
    );
    // registered write port; address/data hold when idle, r_ld remembers a load write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we <= 1'b0;
            r_wa <= '0;
            r_wd <= '0;
            r_ld <= 1'b0;
        end else begin
            r_we <= w_win;
            r_ld <= w_win && !w_alu_win;
            if (w_win) begin
                r_wa <= w_wa;
                r_wd <= w_wd;
            end
        end
    end
    assign WE = r_we;
    assign WA = r_wa;
    assign WD = r_wd;
    assign w_set = (ld_issue && ld_issue_rd != REG_ZERO) ? NUM_REGS'(1) << ld_issue_rd : '0;
    assign w_clr = (r_we && r_ld) ? NUM_REGS'(1) << r_wa : '0;
    // pending scoreboard: load write clears with the register file update, a new issue wins
    always_ff @(posedge clk) begin
        if (rst) r_pend <= '0;
        else r_pend <= (r_pend & ~w_clr) | w_set;
    end
    assign stall = r_pend[rs1] | r_pend[rs2] | r_pend[chk_rd];
endmodule
